enabled_register: RTL and testbench
===================================

Name: enabled_register

Overview:
- Generic clocked storage element with write enable and asynchronous active-high reset.
- Serves as the single primitive behind the codebase's D_FlipFlop (WIDTH=1), register_5 (WIDTH=5) and register_32 (WIDTH=32).
- All pipeline registers are built from instances of it: IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Each instance holds one pipeline field. It updates only when the stage's write (stall-control) signal permits.

Parameters:
- WIDTH, 32, number of stored bits; legal range 1..64; pipeline uses 1, 5 and 32.
- RESET_VALUE, 0 (all bits zero), value loaded into q when reset is asserted; WIDTH bits wide.

Ports:
- clk  input  1  system clock; state changes only on the rising edge, except during reset.
- reset  input  1  asynchronous, active-high reset; forces q to RESET_VALUE.
- write  input  1  synchronous write enable; 1 = capture d at the rising clk edge, 0 = hold.
- d  input  WIDTH  next-value data input.
- q  output  WIDTH  stored value; registered output, no combinational path from d.
- Positional order for instantiation, per the codebase convention: (q, d, write, reset, clk).

Behaviour:
- Reset is asynchronous and active-high.
  - A rising edge of reset sets q to RESET_VALUE immediately, with no clock edge needed.
  - q stays at RESET_VALUE for as long as reset is high, regardless of clk, write or d.
- Priority: reset > write > hold.
  - reset=1 at a clk edge: q = RESET_VALUE even if write=1.
- Normal operation, with reset=0 at the rising clk edge:
  - write=1: q takes the value d had just before the edge. Latency is one edge, and the new value is visible after clock-to-q.
  - write=0: q keeps its previous value, whatever d is doing.
- Reset release:
  - Deasserting reset between edges does not change q.
  - The first rising edge after release, with write=1, loads d.
  - Deasserting reset coincident with a clk edge: reset is treated as still active, so q = RESET_VALUE at that edge.
- Falling clk edges, and changes to d or write between rising edges, have no effect on q.
- Power-up: q is undefined (X in simulation) until the first reset, or until the first rising edge with write=1.
  - The design must not depend on an initial value without reset.
- Width rules:
  - d and q are exactly WIDTH bits; no extension or truncation happens inside the block.
  - Callers storing narrower fields zero-extend externally. Example: a 4-bit ALU op stored in a WIDTH=5 instance as {1'b0, op}, read back as q[3:0].
- No glitches on q other than transitions caused by a clk edge or by reset assertion.
- All bits of an instance are updated together, on the same edge, under the same enable.
- Synthesisable as WIDTH flip-flops with enable and asynchronous clear/preset. No latches, no derived clocks, no gating of clk.
- Alias wrappers must exist with identical behaviour and positional port order (q, d, write, reset, clk):
  - D_FlipFlop: WIDTH=1.
  - register_5: WIDTH=5.
  - register_32: WIDTH=32.
  - All three use RESET_VALUE=0.

Test Plan:
- Capture, WIDTH=32: reset=0, write=1, d=32'h00000004, one rising clk edge -> q=32'h00000004. Then d=32'hDEADBEEF, edge -> q=32'hDEADBEEF.
- Hold, WIDTH=5: load d=5'd5 with write=1 -> q=5'd5. Then write=0, d=5'd31, three edges -> q stays 5'd5.
- Asynchronous reset, WIDTH=32: q=32'hFFFFFFFF, assert reset mid-cycle with no clk edge -> q=0 within the same timestep. q stays 0 across edges while reset=1, even with write=1 and d=32'h12345678.
- Reset release: deassert reset between edges -> q stays 0. Next edge with write=1, d=32'hA5A5A5A5 -> q=32'hA5A5A5A5. Release coincident with an edge -> q=0 at that edge.
- Single bit and zero-extension:
  - WIDTH=1: d=0 then 1 with write=1 -> q follows on successive edges. write=0 -> holds.
  - WIDTH=5 with d={1'b0, 4'd4}: edge -> q=5'd4, q[3:0]=4'd4.
- No false capture: toggle d and write between rising edges and on the falling edge -> q changes only at rising edges where write=1.

Source files
------------

// File: rtl/D_FlipFlop.sv
// Single-bit alias of enabled_register, cleared to zero on reset.
module D_FlipFlop (
    output logic q,
    input  logic d,
    input  logic write,
    input  logic reset,
    input  logic clk
);

    enabled_register #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_reg (
        .q     (q),
        .d     (d),
        .write (write),
        .reset (reset),
        .clk   (clk)
    );

endmodule

// File: rtl/register_32.sv
// 32-bit alias of enabled_register, cleared to zero on reset.
module register_32 (
    output logic [31:0] q,
    input  logic [31:0] d,
    input  logic        write,
    input  logic        reset,
    input  logic        clk
);

    enabled_register #(
        .WIDTH       (32),
        .RESET_VALUE (32'd0)
    ) u_reg (
        .q     (q),
        .d     (d),
        .write (write),
        .reset (reset),
        .clk   (clk)
    );

endmodule

// File: rtl/register_5.sv
// 5-bit alias of enabled_register, cleared to zero on reset.
module register_5 (
    output logic [4:0] q,
    input  logic [4:0] d,
    input  logic       write,
    input  logic       reset,
    input  logic       clk
);

    enabled_register #(
        .WIDTH       (5),
        .RESET_VALUE (5'd0)
    ) u_reg (
        .q     (q),
        .d     (d),
        .write (write),
        .reset (reset),
        .clk   (clk)
    );

endmodule

// File: rtl/enabled_register.sv
// Generic WIDTH-bit register with synchronous write enable and asynchronous active-high reset.
// Every pipeline field register is an instance of this block or one of its fixed-width aliases.
module enabled_register #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             write,
    input  logic             reset,
    input  logic             clk
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (write) begin
            q_d = d;
        end
    end

    // Reset wins over write, including when it is released on a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_enabled_register.sv
// Directed bench for enabled_register and its 1-bit and 5-bit aliases, scoreboard-checked.
module tb_enabled_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        w32, w5, w1;
    logic [31:0] d32, q32;
    logic [4:0]  d5, q5;
    logic        d1, q1;
    logic [31:0] q32_alias;

    logic [63:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    enabled_register #(
        .WIDTH       (32),
        .RESET_VALUE (32'd0)
    ) dut32 (
        .q     (q32),
        .d     (d32),
        .write (w32),
        .reset (reset),
        .clk   (clk)
    );

    register_32 dut32a (
        .q     (q32_alias),
        .d     (d32),
        .write (w32),
        .reset (reset),
        .clk   (clk)
    );

    register_5 dut5 (
        .q     (q5),
        .d     (d5),
        .write (w5),
        .reset (reset),
        .clk   (clk)
    );

    D_FlipFlop dut1 (
        .q     (q1),
        .d     (d1),
        .write (w1),
        .reset (reset),
        .clk   (clk)
    );

    task automatic expect_val(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    task automatic fall();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        w32 = 1'b0; w5 = 1'b0; w1 = 1'b0;
        d32 = '0;   d5 = '0;   d1 = 1'b0;

        // Reset applied before any clock edge.
        #2;
        expect_val(64'd0); check("reset_q32", {32'd0, q32});
        expect_val(64'd0); check("reset_q5", {59'd0, q5});
        expect_val(64'd0); check("reset_q1", {63'd0, q1});

        // Release between edges leaves q alone.
        fall();
        reset = 1'b0;
        #1;
        expect_val(64'd0); check("release_idle_q32", {32'd0, q32});

        // Capture, 32 bits.
        fall(); w32 = 1'b1; d32 = 32'h0000_0004; expect_val(64'h4);
        rise(); check("capture_4", {32'd0, q32});
        fall(); d32 = 32'hDEAD_BEEF; expect_val(64'hDEAD_BEEF); expect_val(64'hDEAD_BEEF);
        rise(); check("capture_deadbeef", {32'd0, q32});
        check("alias32_deadbeef", {32'd0, q32_alias});

        // Hold, 5 bits.
        fall(); w5 = 1'b1; d5 = 5'd5; expect_val(64'd5);
        rise(); check("load5", {59'd0, q5});
        fall(); w5 = 1'b0; d5 = 5'd31;
        for (int i = 0; i < 3; i++) begin
            expect_val(64'd5);
            rise(); check("hold5", {59'd0, q5});
        end

        // Zero-extended 4-bit field in a 5-bit register.
        fall(); w5 = 1'b1; d5 = {1'b0, 4'd4}; expect_val(64'd4); expect_val(64'd4);
        rise(); check("zext_q5", {59'd0, q5});
        check("zext_low4", {60'd0, q5[3:0]});

        // Single bit follows, then holds.
        fall(); w1 = 1'b1; d1 = 1'b0; expect_val(64'd0);
        rise(); check("bit_load0", {63'd0, q1});
        fall(); d1 = 1'b1; expect_val(64'd1);
        rise(); check("bit_load1", {63'd0, q1});
        fall(); w1 = 1'b0; d1 = 1'b0; expect_val(64'd1);
        rise(); check("bit_hold", {63'd0, q1});

        // Asynchronous reset mid-cycle.
        fall(); w32 = 1'b1; d32 = 32'hFFFF_FFFF; expect_val(64'hFFFF_FFFF);
        rise(); check("load_ones", {32'd0, q32});
        #2;
        reset = 1'b1;
        #1;
        expect_val(64'd0); check("async_reset_q32", {32'd0, q32});
        expect_val(64'd0); check("async_reset_q5", {59'd0, q5});
        expect_val(64'd0); check("async_reset_q1", {63'd0, q1});
        d32 = 32'h1234_5678; w32 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_val(64'd0);
            rise(); check("reset_over_write", {32'd0, q32});
        end

        // Release between edges, then load.
        fall(); reset = 1'b0; d32 = 32'hA5A5_A5A5;
        #1;
        expect_val(64'd0); check("release_between_edges", {32'd0, q32});
        expect_val(64'hA5A5_A5A5);
        rise(); check("load_after_release", {32'd0, q32});

        // Release coincident with an edge: reset still wins that edge.
        fall(); reset = 1'b1; d32 = 32'h5A5A_5A5A;
        #1;
        expect_val(64'd0); check("reassert_reset", {32'd0, q32});
        @(posedge clk);
        #0 reset = 1'b0;
        #1;
        expect_val(64'd0); check("release_on_edge", {32'd0, q32});
        expect_val(64'h5A5A_5A5A);
        rise(); check("load_after_edge_release", {32'd0, q32});

        // No false capture from between-edge or falling-edge activity.
        fall(); w32 = 1'b1; d32 = 32'hCAFE_F00D;
        #2; w32 = 1'b0; d32 = 32'h0BAD_0BAD;
        expect_val(64'h5A5A_5A5A);
        rise(); check("no_capture_write_low", {32'd0, q32});
        w32 = 1'b1; d32 = 32'h2222_2222;
        fall(); #1;
        expect_val(64'h5A5A_5A5A); check("no_capture_negedge", {32'd0, q32});
        w32 = 1'b0; d32 = 32'h4444_4444;
        #2; w32 = 1'b1; d32 = 32'h3333_3333;
        expect_val(64'h3333_3333);
        rise(); check("capture_last_value", {32'd0, q32});

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
